// File: rtl/uart_apb_ctrl_if.sv
// APB3 + register-block bundle for the UART APB front-end.
// The master modport is the fabric/register-block side, the slave modport is the controller.
interface uart_apb_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [3:0]        pstrb;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic [3:0]        reg_strb;
    logic              reg_wr_en;
    logic              reg_rd_en;
    logic              reg_ready;
    logic [DATA_W-1:0] reg_rdata;
    logic              tx_enable;
    logic              rx_enable;
    logic              full_tx;
    logic              empty_rx;
    logic              push_tx;
    logic              pop_rx;
    logic [7:0]        err_count;

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        input  reg_rdata, tx_enable, rx_enable, full_tx, empty_rx,
        output prdata, pready, pslverr,
        output reg_addr, reg_wdata, reg_strb, reg_wr_en, reg_rd_en, reg_ready,
        output push_tx, pop_rx, err_count
    );

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        output reg_rdata, tx_enable, rx_enable, full_tx, empty_rx,
        input  prdata, pready, pslverr,
        input  reg_addr, reg_wdata, reg_strb, reg_wr_en, reg_rd_en, reg_ready,
        input  push_tx, pop_rx, err_count
    );
endinterface

// File: rtl/uart_apb_ctrl.sv
// APB3 slave front-end for the UART register block: captures the setup phase,
// inserts WAIT_STATES wait cycles, then issues one access cycle with strobes or PSLVERR.
//
// state     | meaning
// ST_IDLE   | no transfer; waiting for a setup phase (psel=1, penable=0)
// ST_WAIT   | setup latched; pready low while the wait counter runs down
// ST_ACCESS | single completing cycle; pready high, strobes or pslverr
module uart_apb_ctrl #(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_apb_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS} state_t;

    localparam logic [3:0]        WS      = 4'(WAIT_STATES);
    localparam logic [ADDR_W-1:0] A_TX    = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] A_RX    = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] A_STATE = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] A_BAUD  = ADDR_W'(32'h10);
    localparam logic [ADDR_W-1:0] A_IER   = ADDR_W'(32'h14);
    localparam logic [ADDR_W-1:0] A_ISR   = ADDR_W'(32'h18);

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_strb;
    logic              r_write;
    logic [7:0]        r_err_count;

    logic w_setup;
    logic w_capture;
    logic w_access;
    logic w_legal;
    logic w_err;
    logic w_wr_ok;
    logic w_rd_ok;

    assign w_setup   = bus.psel & ~bus.penable;
    // A setup phase is accepted from IDLE and also during ACCESS, so back-to-back transfers skip the idle bubble.
    assign w_capture = w_setup & ((r_state == ST_IDLE) | (r_state == ST_ACCESS));
    assign w_access  = (r_state == ST_ACCESS);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Latch the setup-phase fields and reload the wait counter; run the counter down while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_write <= 1'b0;
        end else if (w_capture) begin
            r_cnt   <= WS;
            r_addr  <= bus.paddr;
            r_wdata <= bus.pwdata;
            r_strb  <= bus.pstrb;
            r_write <= bus.pwrite;
        end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Next-state logic; psel dropping during WAIT aborts the transfer silently.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_setup) w_next = (WS != 4'd0) ? ST_WAIT : ST_ACCESS;
            end
            ST_WAIT: begin
                if (!bus.psel)          w_next = ST_IDLE;
                else if (r_cnt <= 4'd1) w_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (w_setup) w_next = (WS != 4'd0) ? ST_WAIT : ST_ACCESS;
                else         w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Address map decode of the latched address.
    always_comb begin
        w_legal = 1'b0;
        case (r_addr)
            A_TX, A_RX, A_STATE, A_CTRL, A_BAUD, A_IER, A_ISR: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    // FIFO flags are only looked at here, so changes during WAIT never matter.
    assign w_err = ~w_legal
                 | (r_write & ((r_addr == A_RX) | (r_addr == A_STATE)))
                 | (r_write & (r_addr == A_TX) & (bus.full_tx | ~bus.tx_enable))
                 | (~r_write & (r_addr == A_RX) & (bus.empty_rx | ~bus.rx_enable));

    assign w_wr_ok = w_access & r_write & ~w_err;
    assign w_rd_ok = w_access & ~r_write & ~w_err;

    // Saturating count of error responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  r_err_count <= 8'd0;
        else if (w_access && w_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
    end

    assign bus.pready    = w_access;
    assign bus.pslverr   = w_access & w_err;
    assign bus.prdata    = w_rd_ok ? bus.reg_rdata : '0;
    assign bus.reg_addr  = r_addr;
    assign bus.reg_wdata = r_wdata;
    assign bus.reg_strb  = r_strb;
    assign bus.reg_wr_en = w_wr_ok;
    assign bus.reg_rd_en = w_rd_ok;
    assign bus.reg_ready = w_rd_ok;
    // The pop lands at the end of the read cycle, so prdata still carries the head entry.
    assign bus.push_tx   = w_wr_ok & (r_addr == A_TX) & r_strb[0];
    assign bus.pop_rx    = w_rd_ok & (r_addr == A_RX);
    assign bus.err_count = r_err_count;
endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Self-checking bench for uart_apb_ctrl: one DUT with WAIT_STATES=1, one with WAIT_STATES=3,
// directed scenarios plus randomized transfers checked against a register-map reference model.
module tb_uart_apb_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ws3 = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [11:0] paddr = '0;
    logic [15:0] pwdata = '0, reg_rdata = '0;
    logic [3:0]  pstrb = '0;
    logic        tx_enable = 1'b1, rx_enable = 1'b1, full_tx = 1'b0, empty_rx = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_wr = 0, n_rd = 0, n_rdq = 0, n_push = 0, n_pop = 0, n_rdy = 0, n_err = 0;
    int errc [2] = '{0, 0};

    uart_apb_ctrl_if #(.ADDR_W(12), .DATA_W(16)) b1 ();
    uart_apb_ctrl_if #(.ADDR_W(12), .DATA_W(16)) b3 ();

    assign b1.psel = psel & ~ws3;
    assign b3.psel = psel & ws3;
    assign b1.penable = penable;    assign b3.penable = penable;
    assign b1.pwrite = pwrite;      assign b3.pwrite = pwrite;
    assign b1.paddr = paddr;        assign b3.paddr = paddr;
    assign b1.pwdata = pwdata;      assign b3.pwdata = pwdata;
    assign b1.pstrb = pstrb;        assign b3.pstrb = pstrb;
    assign b1.reg_rdata = reg_rdata; assign b3.reg_rdata = reg_rdata;
    assign b1.tx_enable = tx_enable; assign b3.tx_enable = tx_enable;
    assign b1.rx_enable = rx_enable; assign b3.rx_enable = rx_enable;
    assign b1.full_tx = full_tx;    assign b3.full_tx = full_tx;
    assign b1.empty_rx = empty_rx;  assign b3.empty_rx = empty_rx;

    uart_apb_ctrl #(.WAIT_STATES(1), .ADDR_W(12), .DATA_W(16)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    uart_apb_ctrl #(.WAIT_STATES(3), .ADDR_W(12), .DATA_W(16)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    logic        o_pready, o_pslverr;
    logic [15:0] o_prdata, o_wdata;
    logic [11:0] o_addr;
    logic [7:0]  o_err_count;
    assign o_pready    = ws3 ? b3.pready    : b1.pready;
    assign o_pslverr   = ws3 ? b3.pslverr   : b1.pslverr;
    assign o_prdata    = ws3 ? b3.prdata    : b1.prdata;
    assign o_wdata     = ws3 ? b3.reg_wdata : b1.reg_wdata;
    assign o_addr      = ws3 ? b3.reg_addr  : b1.reg_addr;
    assign o_err_count = ws3 ? b3.err_count : b1.err_count;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count every strobe cycle on both DUTs, so stray pulses anywhere show up as deltas.
    always @(negedge clk) begin
        n_wr   <= n_wr   + int'(b1.reg_wr_en) + int'(b3.reg_wr_en);
        n_rd   <= n_rd   + int'(b1.reg_rd_en) + int'(b3.reg_rd_en);
        n_rdq  <= n_rdq  + int'(b1.reg_ready) + int'(b3.reg_ready);
        n_push <= n_push + int'(b1.push_tx)   + int'(b3.push_tx);
        n_pop  <= n_pop  + int'(b1.pop_rx)    + int'(b3.pop_rx);
        n_rdy  <= n_rdy  + int'(b1.pready)    + int'(b3.pready);
        n_err  <= n_err  + int'(b1.pslverr)   + int'(b3.pslverr);
    end

    // Reference model: legal map is word-aligned offsets 0x00..0x18; DATA_RX/STATE read-only;
    // DATA_TX writes need a non-full, enabled TX FIFO; DATA_RX reads need a non-empty, enabled RX FIFO.
    function automatic bit model_err(bit wr, int a, bit ftx, bit ten, bit erx, bit ren);
        if (!((a % 4 == 0) && (a <= 24))) return 1'b1;
        if (wr && (a == 4 || a == 8)) return 1'b1;
        if (wr && a == 0 && (ftx || !ten)) return 1'b1;
        if (!wr && a == 4 && (erx || !ren)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int sat_inc(int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // One complete APB transfer; optionally rerandomizes FIFO flags while pready is low.
    task automatic xfer(input logic wr, input logic [11:0] a, input logic [15:0] wd, input logic [3:0] st,
                        input bit jitter, output int lat, output logic err, output logic [15:0] rd,
                        output logic [15:0] wd_obs, output logic [11:0] a_obs, output int t_done);
        bit done = 0;
        lat = 0; err = 1'bx; rd = 'x; wd_obs = 'x; a_obs = 'x; t_done = 0;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
        @(posedge clk); #1 penable = 1'b1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (o_pready) begin
                err = o_pslverr; rd = o_prdata; wd_obs = o_wdata; a_obs = o_addr; t_done = cyc;
                done = 1;
            end else if (jitter) begin
                full_tx   = ($urandom_range(0, 3) == 0);
                empty_rx  = ($urandom_range(0, 3) == 0);
                tx_enable = ($urandom_range(0, 5) != 0);
                rx_enable = ($urandom_range(0, 5) != 0);
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL xfer_timeout addr=%0h got no pready want pready within 40 cycles", a);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (b1.pready !== 1'b0 || b3.pready !== 1'b0) begin errors++; $display("FAIL rst_pready got %b/%b want 0", b1.pready, b3.pready); end
        checks++; if (b1.pslverr !== 1'b0 || b3.pslverr !== 1'b0) begin errors++; $display("FAIL rst_pslverr got %b/%b want 0", b1.pslverr, b3.pslverr); end
        checks++; if (b1.prdata !== 16'h0 || b3.prdata !== 16'h0) begin errors++; $display("FAIL rst_prdata got %h/%h want 0", b1.prdata, b3.prdata); end
        checks++; if ({b1.reg_wr_en, b1.reg_rd_en, b1.reg_ready, b1.push_tx, b1.pop_rx} !== 5'b0) begin errors++; $display("FAIL rst_strobes got %b want 00000", {b1.reg_wr_en, b1.reg_rd_en, b1.reg_ready, b1.push_tx, b1.pop_rx}); end
        checks++; if ({b1.reg_addr, b1.reg_wdata, b1.reg_strb} !== 32'h0) begin errors++; $display("FAIL rst_latches got %h want 0", {b1.reg_addr, b1.reg_wdata, b1.reg_strb}); end
        checks++; if (b1.err_count !== 8'd0 || b3.err_count !== 8'd0) begin errors++; $display("FAIL rst_err_count got %0d/%0d want 0", b1.err_count, b3.err_count); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_push();
        int lat, t, s_wr, s_push; logic err; logic [15:0] rd, wdo; logic [11:0] ao;
        ws3 = 1'b0; full_tx = 1'b0; tx_enable = 1'b1;
        s_wr = n_wr; s_push = n_push;
        xfer(1'b1, 12'h000, 16'h00A5, 4'h1, 1'b0, lat, err, rd, wdo, ao, t);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency got %0d want 2", lat); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_pslverr got %b want 0", err); end
        checks++; if (wdo !== 16'h00A5) begin errors++; $display("FAIL wr_reg_wdata got %h want 00a5", wdo); end
        checks++; if (n_wr - s_wr !== 1) begin errors++; $display("FAIL wr_reg_wr_en_pulses got %0d want 1", n_wr - s_wr); end
        checks++; if (n_push - s_push !== 1) begin errors++; $display("FAIL wr_push_pulses got %0d want 1", n_push - s_push); end
    endtask

    task automatic test_read_pop();
        int lat, t, s_rd, s_pop; logic err; logic [15:0] rd, wdo; logic [11:0] ao;
        ws3 = 1'b0; empty_rx = 1'b0; rx_enable = 1'b1; reg_rdata = 16'h003C;
        s_rd = n_rd; s_pop = n_pop;
        xfer(1'b0, 12'h004, 16'h0, 4'h0, 1'b0, lat, err, rd, wdo, ao, t);
        checks++; if (rd !== 16'h003C) begin errors++; $display("FAIL rd_prdata got %h want 003c", rd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_pslverr got %b want 0", err); end
        checks++; if (n_pop - s_pop !== 1 || n_rd - s_rd !== 1) begin errors++; $display("FAIL rd_pop_pulses got pop=%0d rd=%0d want 1/1", n_pop - s_pop, n_rd - s_rd); end
        checks++; if (o_err_count !== 8'd0) begin errors++; $display("FAIL rd_err_count got %0d want 0", o_err_count); end
    endtask

    task automatic test_fifo_errors();
        int lat, t, s_wr, s_push, s_pop; logic err; logic [15:0] rd, wdo; logic [11:0] ao;
        ws3 = 1'b0; full_tx = 1'b1;
        s_wr = n_wr; s_push = n_push; s_pop = n_pop;
        xfer(1'b1, 12'h000, 16'h0011, 4'h1, 1'b0, lat, err, rd, wdo, ao, t);
        errc[0] = sat_inc(errc[0]);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL full_tx_pslverr got %b want 1", err); end
        checks++; if (n_wr - s_wr !== 0 || n_push - s_push !== 0) begin errors++; $display("FAIL full_tx_strobes got wr=%0d push=%0d want 0/0", n_wr - s_wr, n_push - s_push); end
        checks++; if (o_err_count !== 8'd1) begin errors++; $display("FAIL full_tx_err_count got %0d want 1", o_err_count); end
        full_tx = 1'b0; empty_rx = 1'b1; reg_rdata = 16'h5555;
        xfer(1'b0, 12'h004, 16'h0, 4'h0, 1'b0, lat, err, rd, wdo, ao, t);
        errc[0] = sat_inc(errc[0]);
        checks++; if (err !== 1'b1 || rd !== 16'h0) begin errors++; $display("FAIL empty_rx_resp got err=%b prdata=%h want 1/0000", err, rd); end
        checks++; if (n_pop - s_pop !== 0) begin errors++; $display("FAIL empty_rx_pop got %0d want 0", n_pop - s_pop); end
        checks++; if (o_err_count !== 8'd2) begin errors++; $display("FAIL empty_rx_err_count got %0d want 2", o_err_count); end
        empty_rx = 1'b0;
    endtask

    task automatic test_illegal();
        int lat, t, s_wr, s_rd, s_err;
        logic err; logic [15:0] rd, wdo; logic [11:0] ao;
        logic [11:0] addrs [3] = '{12'h008, 12'h01C, 12'h002};
        logic        wrs   [3] = '{1'b1, 1'b0, 1'b1};
        ws3 = 1'b0;
        s_wr = n_wr; s_rd = n_rd; s_err = n_err;
        for (int i = 0; i < 3; i++) begin
            xfer(wrs[i], addrs[i], 16'hBEEF, 4'hF, 1'b0, lat, err, rd, wdo, ao, t);
            errc[0] = sat_inc(errc[0]);
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_pslverr addr=%h got %b want 1", addrs[i], err); end
        end
        checks++; if (n_err - s_err !== 3) begin errors++; $display("FAIL illegal_err_pulses got %0d want 3", n_err - s_err); end
        checks++; if (n_wr - s_wr !== 0 || n_rd - s_rd !== 0) begin errors++; $display("FAIL illegal_strobes got wr=%0d rd=%0d want 0/0", n_wr - s_wr, n_rd - s_rd); end
        checks++; if (o_err_count !== 8'd5) begin errors++; $display("FAIL illegal_err_count got %0d want 5", o_err_count); end
    endtask

    task automatic test_random(input logic sel, input int n);
        int lat, t, pick, ws, s_wr, s_rd, s_rdq, s_push, s_pop;
        logic err, wr, e; logic [15:0] rd, wdo, wd, exp_rd; logic [11:0] ao, a; logic [3:0] st;
        int leg [7] = '{0, 4, 8, 12, 16, 20, 24};
        ws3 = sel; ws = sel ? 3 : 1;
        for (int i = 0; i < n; i++) begin
            pick = $urandom_range(0, 9);
            if (pick < 7)       a = 12'(leg[pick]);
            else if (pick == 7) a = 12'h01C;
            else if (pick == 8) a = 12'($urandom_range(0, 31));
            else                a = 12'($urandom);
            wr = 1'($urandom); wd = 16'($urandom); st = 4'($urandom);
            reg_rdata = 16'($urandom);
            full_tx = ($urandom_range(0, 3) == 0); empty_rx = ($urandom_range(0, 3) == 0);
            tx_enable = ($urandom_range(0, 5) != 0); rx_enable = ($urandom_range(0, 5) != 0);
            s_wr = n_wr; s_rd = n_rd; s_rdq = n_rdq; s_push = n_push; s_pop = n_pop;
            xfer(wr, a, wd, st, 1'b1, lat, err, rd, wdo, ao, t);
            e = model_err(wr, int'(a), full_tx, tx_enable, empty_rx, rx_enable);
            if (e) errc[sel] = sat_inc(errc[sel]);
            exp_rd = (!wr && !e) ? reg_rdata : 16'h0;
            checks++; if (lat !== ws + 1) begin errors++; $display("FAIL rnd_latency addr=%h got %0d want %0d", a, lat, ws + 1); end
            checks++; if (err !== e) begin errors++; $display("FAIL rnd_pslverr addr=%h wr=%b got %b want %b", a, wr, err, e); end
            checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd_prdata addr=%h got %h want %h", a, rd, exp_rd); end
            checks++; if (ao !== a || wdo !== wd) begin errors++; $display("FAIL rnd_latched got %h/%h want %h/%h", ao, wdo, a, wd); end
            checks++; if (n_wr - s_wr !== int'(wr && !e)) begin errors++; $display("FAIL rnd_reg_wr_en addr=%h got %0d want %0d", a, n_wr - s_wr, int'(wr && !e)); end
            checks++; if (n_rd - s_rd !== int'(!wr && !e) || n_rdq - s_rdq !== int'(!wr && !e)) begin errors++; $display("FAIL rnd_reg_rd_en addr=%h got %0d/%0d want %0d", a, n_rd - s_rd, n_rdq - s_rdq, int'(!wr && !e)); end
            checks++; if (n_push - s_push !== int'(wr && !e && a == 0 && st[0])) begin errors++; $display("FAIL rnd_push_tx addr=%h got %0d want %0d", a, n_push - s_push, int'(wr && !e && a == 0 && st[0])); end
            checks++; if (n_pop - s_pop !== int'(!wr && !e && a == 4)) begin errors++; $display("FAIL rnd_pop_rx addr=%h got %0d want %0d", a, n_pop - s_pop, int'(!wr && !e && a == 4)); end
            checks++; if (int'(o_err_count) !== errc[sel]) begin errors++; $display("FAIL rnd_err_count got %0d want %0d", o_err_count, errc[sel]); end
        end
        full_tx = 1'b0; empty_rx = 1'b0; tx_enable = 1'b1; rx_enable = 1'b1;
    endtask

    task automatic test_abort();
        int lat, t, s_wr, s_rdy, s_err; logic err; logic [15:0] rd, wdo; logic [11:0] ao;
        ws3 = 1'b1;
        s_wr = n_wr; s_rdy = n_rdy; s_err = n_err;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = 16'h1234; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        checks++; if (n_rdy - s_rdy !== 0) begin errors++; $display("FAIL abort_pready got %0d want 0", n_rdy - s_rdy); end
        checks++; if (n_wr - s_wr !== 0 || n_err - s_err !== 0) begin errors++; $display("FAIL abort_strobes got wr=%0d err=%0d want 0/0", n_wr - s_wr, n_err - s_err); end
        checks++; if (int'(o_err_count) !== errc[1]) begin errors++; $display("FAIL abort_err_count got %0d want %0d", o_err_count, errc[1]); end
        xfer(1'b1, 12'h00C, 16'h4321, 4'hF, 1'b0, lat, err, rd, wdo, ao, t);
        checks++; if (lat !== 4 || err !== 1'b0) begin errors++; $display("FAIL abort_recover got lat=%0d err=%b want 4/0", lat, err); end
    endtask

    task automatic test_back_to_back();
        int t1, t2, s_wr, k; logic a1_ok;
        ws3 = 1'b1; s_wr = n_wr; t1 = 0; t2 = 0; a1_ok = 1'b0;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 16'h0100; pstrb = 4'h3;
        @(posedge clk); #1 penable = 1'b1;
        k = 0;
        while (t1 == 0 && k < 20) begin
            @(negedge clk); k++;
            if (o_pready) begin t1 = cyc; a1_ok = (o_addr == 12'h010); end
        end
        // Next setup presented while the first transfer is still in its access cycle.
        penable = 1'b0; paddr = 12'h014; pwdata = 16'h0003;
        @(posedge clk); #1 penable = 1'b1;
        k = 0;
        while (t2 == 0 && k < 20) begin
            @(negedge clk); k++;
            if (o_pready) t2 = cyc;
        end
        checks++; if (o_addr !== 12'h014 || !a1_ok) begin errors++; $display("FAIL b2b_addr got %h first_ok=%b want 014/1", o_addr, a1_ok); end
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        checks++; if (t1 == 0 || t2 - t1 !== 4) begin errors++; $display("FAIL b2b_spacing got %0d want 4", t2 - t1); end
        checks++; if (n_wr - s_wr !== 2) begin errors++; $display("FAIL b2b_reg_wr_en got %0d want 2", n_wr - s_wr); end
    endtask

    task automatic test_reset_mid();
        int lat, t, s_pop; logic err; logic [15:0] rd, wdo; logic [11:0] ao;
        ws3 = 1'b1; empty_rx = 1'b0; rx_enable = 1'b1; reg_rdata = 16'h0077;
        s_pop = n_pop;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h004;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({b3.pready, b3.pslverr, b3.reg_rd_en, b3.reg_ready, b3.pop_rx} !== 5'b0) begin errors++; $display("FAIL rstmid_ctrl got %b want 00000", {b3.pready, b3.pslverr, b3.reg_rd_en, b3.reg_ready, b3.pop_rx}); end
        checks++; if (b3.prdata !== 16'h0 || b3.reg_addr !== 12'h0 || b3.err_count !== 8'd0) begin errors++; $display("FAIL rstmid_data got %h/%h/%0d want 0/0/0", b3.prdata, b3.reg_addr, b3.err_count); end
        errc[0] = 0; errc[1] = 0;
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        checks++; if (n_pop - s_pop !== 0) begin errors++; $display("FAIL rstmid_pop got %0d want 0", n_pop - s_pop); end
        xfer(1'b0, 12'h004, 16'h0, 4'h0, 1'b0, lat, err, rd, wdo, ao, t);
        checks++; if (lat !== 4 || err !== 1'b0 || rd !== 16'h0077) begin errors++; $display("FAIL rstmid_recover got lat=%0d err=%b prdata=%h want 4/0/0077", lat, err, rd); end
        checks++; if (n_pop - s_pop !== 1) begin errors++; $display("FAIL rstmid_recover_pop got %0d want 1", n_pop - s_pop); end
    endtask

    task automatic test_saturate();
        int lat, t, s_err; logic err; logic [15:0] rd, wdo; logic [11:0] ao;
        ws3 = 1'b0; s_err = n_err;
        for (int i = 0; i < 260; i++) begin
            xfer(1'b0, 12'h01C, 16'h0, 4'h0, 1'b0, lat, err, rd, wdo, ao, t);
            errc[0] = sat_inc(errc[0]);
            if (i == 253) begin
                checks++; if (int'(o_err_count) !== errc[0]) begin errors++; $display("FAIL sat_preload got %0d want %0d", o_err_count, errc[0]); end
            end
        end
        checks++; if (o_err_count !== 8'd255 || errc[0] != 255) begin errors++; $display("FAIL sat_err_count got %0d want 255", o_err_count); end
        checks++; if (n_err - s_err !== 260) begin errors++; $display("FAIL sat_pslverr_pulses got %0d want 260", n_err - s_err); end
    endtask

    initial begin
        test_reset();
        test_write_push();
        test_read_pop();
        test_fifo_errors();
        test_illegal();
        test_random(1'b0, 40);
        test_random(1'b1, 20);
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_apb_ctrl.md
Name: uart_apb_ctrl

Overview:
- APB3 slave front-end that sequences every bus access to the UART register file and its FIFOs.
- Captures the APB setup phase and inserts programmable wait states.
- Produces single-cycle register write/read strobes, TX-FIFO push and RX-FIFO pop pulses.
- Flags illegal accesses with PSLVERR. Sits between the system APB fabric and the UART register block.

Parameters:
- WAIT_STATES, 1, number of wait cycles (pready low) inserted before the completing access cycle; legal 0..15.
- ADDR_W, 12, APB address width.
- DATA_W, 16, APB data width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  APB direction (1 = write)
- paddr  in  ADDR_W  APB address
- pwdata  in  DATA_W  APB write data
- pstrb  in  4  APB byte strobes
- prdata  out  DATA_W  APB read data
- pready  out  1  APB ready
- pslverr  out  1  APB error
- reg_addr  out  ADDR_W  latched address to register block
- reg_wdata  out  DATA_W  latched write data
- reg_strb  out  4  latched strobes
- reg_wr_en  out  1  one-cycle write strobe
- reg_rd_en  out  1  read enable
- reg_ready  out  1  read-data-valid qualifier to register block
- reg_rdata  in  DATA_W  read data from register block
- tx_enable  in  1  TX enabled (CONTROL bit 0)
- rx_enable  in  1  RX enabled (CONTROL bit 1)
- full_tx  in  1  TX FIFO full
- empty_rx  in  1  RX FIFO empty
- push_tx  out  1  one-cycle TX FIFO push
- pop_rx  out  1  one-cycle RX FIFO pop
- err_count  out  8  saturating count of PSLVERR responses

Behaviour:
- Reset (async, rst_n low): state = IDLE, wait counter = 0, err_count = 0, reg_addr/reg_wdata/reg_strb = 0. All strobes, pready, pslverr and prdata are 0.
- Register map: legal offsets are 0x00 DATA_TX, 0x04 DATA_RX, 0x08 STATE, 0x0C CONTROL, 0x10 BAUDDIV, 0x14 IER, 0x18 ISR.
- FSM states are IDLE, WAIT, ACCESS.
- IDLE:
  - On a clock edge with psel=1 and penable=0, latch paddr, pwdata, pstrb and pwrite, and load the wait counter with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, else ACCESS.
- WAIT:
  - pready=0; the counter decrements each cycle; go to ACCESS when the counter reaches 1.
  - psel=0 here is an abort: return to IDLE with no strobes, no error and no err_count change.
- ACCESS (exactly one cycle): pready=1.
  - Error classification uses the latched address/direction plus the live FIFO flags, sampled in the ACCESS cycle. pslverr=1 when any of:
    - address not in the map (includes misaligned, addr[1:0]!=0);
    - write to 0x04 or 0x08 (read-only);
    - write to 0x00 with full_tx=1 or tx_enable=0;
    - read of 0x04 with empty_rx=1 or rx_enable=0.
  - Write, no error: reg_wr_en=1 for this cycle. push_tx=1 additionally if addr=0x00 and reg_strb[0]=1.
  - Read, no error: reg_rd_en=1 and reg_ready=1 for this cycle; prdata = reg_rdata. pop_rx=1 additionally if addr=0x04. The pop takes effect after the data is sampled: same-cycle read returns the head entry.
  - Error: reg_wr_en, reg_rd_en, push_tx and pop_rx all stay 0; prdata=0; err_count increments, saturating at 255.
  - Exit: go to IDLE. If psel=1 and penable=0 in this cycle (back-to-back setup), go directly through the IDLE capture path, i.e. latch and go to WAIT/ACCESS with no idle bubble.
- prdata is 0 outside an error-free read ACCESS cycle.
- Total latency: pready high WAIT_STATES+1 cycles after the setup-phase edge.
- FIFO flags are sampled only in ACCESS. Changes during WAIT do not affect the decision.
- Asserting rst_n low mid-transfer returns to IDLE immediately; no strobe is emitted.
- Access with penable=1 in IDLE (protocol violation): ignored, stays IDLE.

Test Plan:
- WAIT_STATES=1: write 0x00, pwdata=0x00A5, pstrb=0x1, full_tx=0, tx_enable=1 -> pready high 2 cycles after setup; reg_wr_en and push_tx pulse for exactly one cycle; reg_wdata=0x00A5; pslverr=0.
- Read 0x04 with reg_rdata=0x003C, empty_rx=0, rx_enable=1 -> prdata=0x003C in the pready cycle; pop_rx one pulse; err_count unchanged.
- Write 0x00 with full_tx=1 -> pslverr=1 with pready; no reg_wr_en or push_tx; err_count 0->1. Read 0x04 with empty_rx=1 -> pslverr=1, no pop_rx; err_count=2.
- Write to 0x08, then access 0x1C and 0x02 -> three PSLVERR responses with no strobes. Then preload 254 errors -> err_count saturates at 255.
- WAIT_STATES=3: deassert psel in the 2nd wait cycle -> FSM returns to IDLE; no strobes, no pslverr. Separately, two back-to-back writes 0x10/0x14 -> no idle cycle between; one reg_wr_en per transfer.
- Assert rst_n low during WAIT of a DATA_RX read -> all outputs 0 immediately; no pop_rx after release; next transfer completes normally.
